// File: rtl/writeback_unit_if.sv
// Writeback stage bus: memory-stage handshake, data-memory read response,
// register file write port and status outputs.
interface writeback_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instruction;
    logic [XLEN-1:0]  in_alu_result;
    logic [XLEN-1:0]  in_pc_plus4;
    logic [1:0]       in_wb_sel;
    logic [1:0]       in_addr_lo;
    logic             dmem_rvalid;
    logic [31:0]      dmem_rdata;
    logic [4:0]       waddr;
    logic [XLEN-1:0]  wdata;
    logic             registers_wen;
    logic             load_busy;
    logic [4:0]       pending_rd;
    logic [CNT_W-1:0] retired_count;

    // Memory stage / data memory side
    modport master (
        output in_valid, in_instruction, in_alu_result, in_pc_plus4,
               in_wb_sel, in_addr_lo, dmem_rvalid, dmem_rdata,
        input  in_ready, waddr, wdata, registers_wen, load_busy,
               pending_rd, retired_count
    );

    // Writeback unit side
    modport slave (
        input  in_valid, in_instruction, in_alu_result, in_pc_plus4,
               in_wb_sel, in_addr_lo, dmem_rvalid, dmem_rdata,
        output in_ready, waddr, wdata, registers_wen, load_busy,
               pending_rd, retired_count
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: final pipeline stage. Commits ALU / PC+4 results one cycle
// after acceptance, and loads one cycle after the data-memory response, with
// byte/halfword extraction and sign/zero extension. Counts retirements.
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             rst,
    writeback_unit_if.slave wb
);

    localparam logic [0:0] ACCEPT    = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [0:0]       state;
    logic [4:0]       ld_rd;
    logic [2:0]       ld_funct3;
    logic [1:0]       ld_addr_lo;

    logic [4:0]       in_rd;
    logic [2:0]       in_funct3;
    logic             accept;
    logic             load_done;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  load_data;

    logic             commit_fire;
    logic             commit_wen;
    logic [4:0]       commit_addr;
    logic [XLEN-1:0]  commit_data;

    logic [4:0]       waddr_q;
    logic [XLEN-1:0]  wdata_q;
    logic             wen_q;
    logic [CNT_W-1:0] count_q;

    assign in_rd     = wb.in_instruction[11:7];
    assign in_funct3 = wb.in_instruction[14:12];
    assign accept    = wb.in_valid && (state == ACCEPT);
    assign load_done = (state == LOAD_WAIT) && wb.dmem_rvalid;

    // Select the addressed byte/halfword of the returned word and extend it
    always_comb begin
        ld_byte = wb.dmem_rdata[7:0];
        case (ld_addr_lo)
            2'd0:    ld_byte = wb.dmem_rdata[7:0];
            2'd1:    ld_byte = wb.dmem_rdata[15:8];
            2'd2:    ld_byte = wb.dmem_rdata[23:16];
            default: ld_byte = wb.dmem_rdata[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? wb.dmem_rdata[31:16] : wb.dmem_rdata[15:0];
        case (ld_funct3)
            F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  load_data = {24'b0, ld_byte};
            F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  load_data = {16'b0, ld_half};
            default: load_data = wb.dmem_rdata;
        endcase
    end

    // Decide what, if anything, commits at the next clock edge
    always_comb begin
        commit_fire = 1'b0;
        commit_wen  = 1'b0;
        commit_addr = in_rd;
        commit_data = wb.in_alu_result;
        if (load_done) begin
            commit_fire = 1'b1;
            commit_wen  = (ld_rd != 5'd0);
            commit_addr = ld_rd;
            commit_data = load_data;
        end else if (accept && (wb.in_wb_sel != SEL_LOAD)) begin
            commit_fire = 1'b1;
            commit_wen  = (in_rd != 5'd0) &&
                          ((wb.in_wb_sel == SEL_ALU) || (wb.in_wb_sel == SEL_PC4));
            commit_addr = in_rd;
            commit_data = (wb.in_wb_sel == SEL_PC4) ? wb.in_pc_plus4
                                                     : wb.in_alu_result;
        end
    end

    // FSM and latched load context; reset abandons any outstanding load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ACCEPT;
            ld_rd      <= '0;
            ld_funct3  <= '0;
            ld_addr_lo <= '0;
        end else begin
            case (state)
                ACCEPT: begin
                    if (accept && (wb.in_wb_sel == SEL_LOAD)) begin
                        state      <= LOAD_WAIT;
                        ld_rd      <= in_rd;
                        ld_funct3  <= in_funct3;
                        ld_addr_lo <= wb.in_addr_lo;
                    end
                end
                LOAD_WAIT: begin
                    if (wb.dmem_rvalid) begin
                        state <= ACCEPT;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

    // Register file write port: waddr/wdata only move when a write happens
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= commit_fire && commit_wen;
            if (commit_fire && commit_wen) begin
                waddr_q <= commit_addr;
                wdata_q <= commit_data;
            end
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (commit_fire) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign wb.in_ready      = (state == ACCEPT);
    assign wb.load_busy     = (state == LOAD_WAIT);
    assign wb.pending_rd    = (state == LOAD_WAIT) ? ld_rd : '0;
    assign wb.registers_wen = wen_q;
    assign wb.waddr         = waddr_q;
    assign wb.wdata         = wdata_q;
    assign wb.retired_count = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: scoreboard of expected commits,
// one task per scenario, second instance with a 4-bit counter for wrap.
module tb_writeback_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    writeback_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
    writeback_unit_if #(.XLEN(32), .CNT_W(4))  bus4 ();

    writeback_unit #(.XLEN(32), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .wb(bus));
    writeback_unit #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .wb(bus4));

    typedef struct {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb4[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_cnt = '0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    function automatic logic [31:0] instr(input logic [4:0] rd, input logic [2:0] f3);
        return {17'b0, f3, rd, 7'h03};
    endfunction

    // Reference model for one commit: write only when enabled, else hold
    task automatic push_commit(input logic [4:0] rd, input logic writes, input logic [31:0] data);
        exp_t e;
        e.wen = writes && (rd != 5'd0);
        if (e.wen) begin
            last_addr = rd;
            last_data = data;
        end
        e.addr = last_addr;
        e.data = last_data;
        sb.push_back(e);
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_instruction = '0; bus.in_alu_result = '0;
        bus.in_pc_plus4 = '0; bus.in_wb_sel = '0; bus.in_addr_lo = '0;
        bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
        bus4.in_valid = 0; bus4.in_instruction = '0; bus4.in_alu_result = '0;
        bus4.in_pc_plus4 = '0; bus4.in_wb_sel = '0; bus4.in_addr_lo = '0;
        bus4.dmem_rvalid = 0; bus4.dmem_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (bus.registers_wen !== 1'b0) $display("FAIL reset_wen got %b exp 0", bus.registers_wen); else passes++;
        checks++; if (bus.waddr !== 5'd0) $display("FAIL reset_waddr got %0d exp 0", bus.waddr); else passes++;
        checks++; if (bus.wdata !== 32'd0) $display("FAIL reset_wdata got %h exp 0", bus.wdata); else passes++;
        checks++; if (bus.load_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.load_busy); else passes++;
        checks++; if (bus.pending_rd !== 5'd0) $display("FAIL reset_pending got %0d exp 0", bus.pending_rd); else passes++;
        checks++; if (bus.retired_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", bus.retired_count); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.in_ready); else passes++;
        rst = 1;
    endtask

    task automatic test_alu();
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1; bus.in_instruction = instr(5'd5, 3'd0);
        bus.in_alu_result = 32'h0000_1234; bus.in_wb_sel = 2'b00;
        push_commit(5'd5, 1'b1, 32'h0000_1234);
        @(posedge clk); #1;
        bus.in_valid = 0;
        e = sb.pop_front();
        checks++; if (bus.registers_wen !== e.wen) $display("FAIL alu_wen got %b exp %b", bus.registers_wen, e.wen); else passes++;
        checks++; if (bus.waddr !== e.addr) $display("FAIL alu_waddr got %0d exp %0d", bus.waddr, e.addr); else passes++;
        checks++; if (bus.wdata !== e.data) $display("FAIL alu_wdata got %h exp %h", bus.wdata, e.data); else passes++;
        checks++; if (bus.retired_count !== exp_cnt) $display("FAIL alu_count got %0d exp %0d", bus.retired_count, exp_cnt); else passes++;
        @(posedge clk); #1;
        checks++; if (bus.registers_wen !== 1'b0) $display("FAIL alu_pulse got %b exp 0", bus.registers_wen); else passes++;
        // wb_sel=11 with nonzero rd retires without writing; port holds
        @(negedge clk);
        bus.in_valid = 1; bus.in_instruction = instr(5'd6, 3'd0);
        bus.in_alu_result = 32'h5555_AAAA; bus.in_wb_sel = 2'b11;
        push_commit(5'd6, 1'b0, 32'h5555_AAAA);
        @(posedge clk); #1;
        bus.in_valid = 0;
        e = sb.pop_front();
        checks++; if (bus.registers_wen !== e.wen) $display("FAIL nowrite_wen got %b exp %b", bus.registers_wen, e.wen); else passes++;
        checks++; if (bus.waddr !== e.addr) $display("FAIL nowrite_waddr got %0d exp %0d", bus.waddr, e.addr); else passes++;
        checks++; if (bus.wdata !== e.data) $display("FAIL nowrite_wdata got %h exp %h", bus.wdata, e.data); else passes++;
        checks++; if (bus.retired_count !== exp_cnt) $display("FAIL nowrite_count got %0d exp %0d", bus.retired_count, exp_cnt); else passes++;
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [4:0] rd, input logic [1:0] alo,
                             input logic [31:0] rdata, input int delay, input logic [31:0] exp_data);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1; bus.in_instruction = instr(rd, f3);
        bus.in_wb_sel = 2'b01; bus.in_addr_lo = alo; bus.in_alu_result = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.in_valid = 0;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        checks++; if (bus.registers_wen !== 1'b0) $display("FAIL ld_accept_wen f3=%0d got %b exp 0", f3, bus.registers_wen); else passes++;
        for (int i = 0; i <= delay; i++) begin
            checks++; if (bus.in_ready !== 1'b0) $display("FAIL ld_ready f3=%0d got %b exp 0", f3, bus.in_ready); else passes++;
            checks++; if (bus.load_busy !== 1'b1) $display("FAIL ld_busy f3=%0d got %b exp 1", f3, bus.load_busy); else passes++;
            checks++; if (bus.pending_rd !== rd) $display("FAIL ld_pending got %0d exp %0d", bus.pending_rd, rd); else passes++;
            if (i < delay) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        bus.dmem_rvalid = 1; bus.dmem_rdata = rdata;
        push_commit(rd, 1'b1, exp_data);
        @(posedge clk); #1;
        bus.dmem_rvalid = 0; bus.dmem_rdata = '0;
        e = sb.pop_front();
        checks++; if (bus.registers_wen !== e.wen) $display("FAIL ld_wen f3=%0d rd=%0d got %b exp %b", f3, rd, bus.registers_wen, e.wen); else passes++;
        checks++; if (bus.waddr !== e.addr) $display("FAIL ld_waddr f3=%0d got %0d exp %0d", f3, bus.waddr, e.addr); else passes++;
        checks++; if (bus.wdata !== e.data) $display("FAIL ld_wdata f3=%0d alo=%0d got %h exp %h", f3, alo, bus.wdata, e.data); else passes++;
        checks++; if (bus.retired_count !== exp_cnt) $display("FAIL ld_count got %0d exp %0d", bus.retired_count, exp_cnt); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL ld_done_ready got %b exp 1", bus.in_ready); else passes++;
        checks++; if (bus.load_busy !== 1'b0) $display("FAIL ld_done_busy got %b exp 0", bus.load_busy); else passes++;
        checks++; if (bus.pending_rd !== 5'd0) $display("FAIL ld_done_pending got %0d exp 0", bus.pending_rd); else passes++;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [4:0]  rds  [3] = '{5'd0, 5'd1, 5'd31};
        logic [1:0]  sels [3] = '{2'b00, 2'b10, 2'b00};
        logic [31:0] alus [3] = '{32'h0000_0BAD, 32'h0000_0BAD, 32'hA5A5_0F0F};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_instruction = instr(rds[i], 3'd0);
            bus.in_wb_sel = sels[i]; bus.in_alu_result = alus[i]; bus.in_pc_plus4 = 32'h0000_0104;
            push_commit(rds[i], 1'b1, (sels[i] == 2'b10) ? 32'h0000_0104 : alus[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++; if (bus.registers_wen !== e.wen) $display("FAIL b2b_wen[%0d] got %b exp %b", i, bus.registers_wen, e.wen); else passes++;
            checks++; if (bus.waddr !== e.addr) $display("FAIL b2b_waddr[%0d] got %0d exp %0d", i, bus.waddr, e.addr); else passes++;
            checks++; if (bus.wdata !== e.data) $display("FAIL b2b_wdata[%0d] got %h exp %h", i, bus.wdata, e.data); else passes++;
            checks++; if (bus.retired_count !== exp_cnt) $display("FAIL b2b_count[%0d] got %0d exp %0d", i, bus.retired_count, exp_cnt); else passes++;
            checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b exp 1", i, bus.in_ready); else passes++;
        end
        bus.in_valid = 0;
    endtask

    task automatic test_stray_rvalid();
        @(negedge clk);
        bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h8765_4321;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        checks++; if (bus.registers_wen !== 1'b0) $display("FAIL stray_wen got %b exp 0", bus.registers_wen); else passes++;
        checks++; if (bus.retired_count !== exp_cnt) $display("FAIL stray_count got %0d exp %0d", bus.retired_count, exp_cnt); else passes++;
        checks++; if (bus.wdata !== last_data) $display("FAIL stray_wdata got %h exp %h", bus.wdata, last_data); else passes++;
        checks++; if (bus.load_busy !== 1'b0) $display("FAIL stray_busy got %b exp 0", bus.load_busy); else passes++;
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        bus.in_valid = 1; bus.in_instruction = instr(5'd9, 3'b010); bus.in_wb_sel = 2'b01;
        @(posedge clk); #1;
        bus.in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        sb.delete();
        exp_cnt = '0; last_addr = '0; last_data = '0;
        checks++; if (bus.load_busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", bus.load_busy); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", bus.in_ready); else passes++;
        checks++; if (bus.pending_rd !== 5'd0) $display("FAIL rstmid_pending got %0d exp 0", bus.pending_rd); else passes++;
        checks++; if (bus.retired_count !== 32'd0) $display("FAIL rstmid_count got %0d exp 0", bus.retired_count); else passes++;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        bus.dmem_rvalid = 1; bus.dmem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        checks++; if (bus.registers_wen !== 1'b0) $display("FAIL rstmid_wen got %b exp 0", bus.registers_wen); else passes++;
        checks++; if (bus.retired_count !== exp_cnt) $display("FAIL rstmid_post_count got %0d exp %0d", bus.retired_count, exp_cnt); else passes++;
        checks++; if (bus.waddr !== 5'd0) $display("FAIL rstmid_waddr got %0d exp 0", bus.waddr); else passes++;
        checks++; if (bus.wdata !== 32'd0) $display("FAIL rstmid_wdata got %h exp 0", bus.wdata); else passes++;
        checks++; if (bus.load_busy !== 1'b0) $display("FAIL rstmid_post_busy got %b exp 0", bus.load_busy); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_post_ready got %b exp 1", bus.in_ready); else passes++;
    endtask

    task automatic test_wrap();
        exp_t       e;
        logic [3:0] cnt4 = '0;
        @(negedge clk);
        bus4.dmem_rvalid = 1; bus4.dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus4.dmem_rvalid = 0;
        checks++; if (bus4.registers_wen !== 1'b0) $display("FAIL wrap_stray_wen got %b exp 0", bus4.registers_wen); else passes++;
        checks++; if (bus4.retired_count !== 4'd0) $display("FAIL wrap_stray_count got %0d exp 0", bus4.retired_count); else passes++;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus4.in_valid = 1; bus4.in_instruction = instr(5'((i % 31) + 1), 3'd0);
            bus4.in_wb_sel = 2'b00; bus4.in_alu_result = 32'(i) * 32'h0001_0011;
            e.wen = 1'b1; e.addr = 5'((i % 31) + 1); e.data = 32'(i) * 32'h0001_0011;
            sb4.push_back(e);
            cnt4 = cnt4 + 4'd1;
            @(posedge clk); #1;
            e = sb4.pop_front();
            checks++; if (bus4.registers_wen !== e.wen) $display("FAIL wrap_wen[%0d] got %b exp %b", i, bus4.registers_wen, e.wen); else passes++;
            checks++; if (bus4.waddr !== e.addr) $display("FAIL wrap_waddr[%0d] got %0d exp %0d", i, bus4.waddr, e.addr); else passes++;
            checks++; if (bus4.wdata !== e.data) $display("FAIL wrap_wdata[%0d] got %h exp %h", i, bus4.wdata, e.data); else passes++;
            checks++; if (bus4.retired_count !== cnt4) $display("FAIL wrap_count[%0d] got %0d exp %0d", i, bus4.retired_count, cnt4); else passes++;
        end
        bus4.in_valid = 0;
        @(posedge clk); #1;
        checks++; if (bus4.retired_count !== 4'd0) $display("FAIL wrap_final got %0d exp 0", bus4.retired_count); else passes++;
        checks++; if (bus4.registers_wen !== 1'b0) $display("FAIL wrap_idle_wen got %b exp 0", bus4.registers_wen); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d/%0d checks", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load(3'b000, 5'd3,  2'd2, 32'h0080_0000, 2, 32'hFFFF_FF80);
        test_load(3'b101, 5'd7,  2'd2, 32'hBEEF_0000, 1, 32'h0000_BEEF);
        test_load(3'b001, 5'd7,  2'd2, 32'hBEEF_0000, 1, 32'hFFFF_BEEF);
        test_load(3'b100, 5'd8,  2'd3, 32'h8012_3456, 0, 32'h0000_0080);
        test_load(3'b000, 5'd9,  2'd1, 32'h0000_7F00, 0, 32'h0000_007F);
        test_load(3'b001, 5'd10, 2'd1, 32'h1234_8001, 1, 32'hFFFF_8001);
        test_load(3'b010, 5'd11, 2'd3, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        test_load(3'b011, 5'd12, 2'd1, 32'h1357_2468, 0, 32'h1357_2468);
        test_load(3'b010, 5'd0,  2'd0, 32'h7777_7777, 1, 32'h7777_7777);
        test_back_to_back();
        test_stray_rvalid();
        test_reset_mid_load();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final stage of the pipelined core; accepts completed instructions from the memory stage and drives the register file write port (waddr, wdata, registers_wen).
- Selects the writeback source: ALU result, load data, or PC+4.
- Waits for the data-memory read response before committing a load, and aligns/extends the returned data.
- Exposes load-busy status for hazard logic and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- CNT_W, 32, width of retired_count.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  unit can accept an instruction this cycle.
- in_instruction  in  32  instruction word; rd=[11:7], funct3=[14:12].
- in_alu_result  in  XLEN  ALU result.
- in_pc_plus4  in  XLEN  PC+4, used for JAL/JALR.
- in_wb_sel  in  2  00=ALU, 01=load, 10=PC+4, 11=no write.
- in_addr_lo  in  2  byte offset of the load address.
- dmem_rvalid  in  1  data memory read response valid.
- dmem_rdata  in  32  raw aligned word from data memory.
- waddr  out  5  register file write address.
- wdata  out  XLEN  register file write data.
- registers_wen  out  1  register file write enable, single-cycle pulse.
- load_busy  out  1  unit is waiting on a load response.
- pending_rd  out  5  rd of the outstanding load, else 0.
- retired_count  out  CNT_W  completed-instruction count.

Behaviour:
- Reset (rst low, asynchronous):
  - state=ACCEPT.
  - waddr=0, wdata=0, registers_wen=0.
  - load_busy=0, pending_rd=0, retired_count=0.
  - Any outstanding load is abandoned; a dmem_rvalid arriving after reset release is ignored.
- States: ACCEPT, LOAD_WAIT.
- ACCEPT:
  - in_ready=1.
  - Handshake on in_valid&in_ready.
  - wb_sel 00, 10 or 11: commit is registered.
    - Next cycle registers_wen=(rd!=0 && wb_sel!=11), waddr=rd, wdata=ALU result or PC+4.
    - Stay in ACCEPT; back-to-back accepts give one commit per cycle.
  - wb_sel 01: latch rd, funct3 and addr_lo; go to LOAD_WAIT. No write that cycle.
- LOAD_WAIT:
  - in_ready=0, load_busy=1, pending_rd=latched rd.
  - On dmem_rvalid: next cycle registers_wen=(rd!=0), waddr=rd, wdata=extracted data; state returns to ACCEPT in that same next cycle.
  - No timeout; waits indefinitely.
- dmem_rvalid while in ACCEPT: ignored.
- registers_wen is high for exactly one cycle per commit; otherwise 0. waddr/wdata hold their last values when registers_wen=0.
- Load extraction (funct3):
  - 000 LB: byte at addr_lo, sign-extended.
  - 100 LBU: byte at addr_lo, zero-extended.
  - 001 LH: halfword selected by addr_lo[1], sign-extended.
  - 101 LHU: halfword selected by addr_lo[1], zero-extended.
  - 010 LW: full word.
  - Other funct3: treated as LW.
  - addr_lo[0] is ignored for halfwords; addr_lo is ignored for words; misalignment is not trapped.
- x0: rd=0 never asserts registers_wen, but still retires.
- retired_count:
  - Increments by 1 in the commit cycle of every instruction, including rd=0 and wb_sel=11.
  - Wraps modulo 2^CNT_W.
- Latency:
  - Non-load: commit 1 cycle after acceptance.
  - Load: commit 1 cycle after dmem_rvalid.

Test Plan:
- Reset release, then in_valid with rd=5, wb_sel=00, alu=0x0000_1234 -> next cycle registers_wen=1, waddr=5, wdata=0x1234, retired_count=1.
- LB rd=3, addr_lo=2, then dmem_rdata=0x0080_0000 with rvalid 3 cycles later -> in_ready=0 and load_busy=1 while waiting, pending_rd=3; one cycle after rvalid wdata=0xFFFF_FF80, waddr=3.
- LHU rd=7, addr_lo=2, dmem_rdata=0xBEEF_0000 -> wdata=0x0000_BEEF. LH with the same stimulus -> wdata=0xFFFF_BEEF.
- rd=0, wb_sel=00, followed back-to-back by JAL-type rd=1, wb_sel=10, pc_plus4=0x104 -> first commit has registers_wen=0; second has waddr=1, wdata=0x104; retired_count=2 after two consecutive commit cycles.
- Load accepted, rst driven low mid-LOAD_WAIT, released, then stray dmem_rvalid -> all outputs 0, state ACCEPT, no write, counter stays 0.
- Stray dmem_rvalid in ACCEPT plus 2^CNT_W retires with CNT_W overridden to 4 -> no spurious write; counter wraps to 0 after 16 retires.
